// File: rtl/osd_dbg_pkg.sv
// Shared types and helpers for the OSD debug-overlay scheduler.
package osd_dbg_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_e;

    localparam int DBG_W_DEF = 8;
    localparam int SRC_W     = 3;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/osd_rr_arbiter.sv
// Combinational round-robin pick over pending sources, starting after last_src.
module osd_rr_arbiter
    import osd_dbg_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [SRC_W-1:0]   last_src,
    output logic               any,
    output logic [SRC_W-1:0]   sel
);

    int idx;

    // k=NUM_REQ wraps back to last_src itself, so it only wins when alone.
    always_comb begin
        any = 1'b0;
        sel = '0;
        idx = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_src) + k) % NUM_REQ;
            if (!any && pending[idx]) begin
                any = 1'b1;
                sel = SRC_W'(idx);
            end
        end
    end

endmodule

// File: rtl/osd_debug_scheduler.sv
// Frame-synchronous round-robin sharing of the OSD debug overlay; outputs only
// change on the VBLANK rising edge so the displayed hex never tears.
module osd_debug_scheduler
    import osd_dbg_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DWELL_FRAMES = 60,
    parameter int DBG_W        = DBG_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     pixel_ce,
    input  logic                     VBLANK,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*DBG_W-1:0] req_value,
    output logic [NUM_REQ-1:0]       req_ack,
    output logic [DBG_W-1:0]         debug_value,
    output logic [SRC_W-1:0]         debug_src,
    output logic                     osd_enable,
    output logic                     frame_tick
);

    localparam int DW = (clog2(DWELL_FRAMES) > 1) ? clog2(DWELL_FRAMES) : 1;
    localparam logic [DW-1:0]    DWELL_INIT = DW'(DWELL_FRAMES - 1);
    localparam logic [SRC_W-1:0] LAST_RST   = SRC_W'(NUM_REQ - 1);

    state_e                          state, state_nxt;
    logic                            vb_prev;
    logic [NUM_REQ-1:0][DBG_W-1:0]   shadow;
    logic [NUM_REQ-1:0]              pending;
    logic [NUM_REQ-1:0]              clr;
    logic [SRC_W-1:0]                last_src;
    logic [DW-1:0]                   dwell;
    logic                            any;
    logic [SRC_W-1:0]                sel;
    logic [DBG_W-1:0]                sel_val;
    logic                            grant, dwell_dec, en_off;

    osd_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .pending  (pending),
        .last_src (last_src),
        .any      (any),
        .sel      (sel)
    );

    always_comb begin
        sel_val = '0;
        clr     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == SRC_W'(i)) begin
                sel_val = shadow[i];
                clr[i]  = grant;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        dwell_dec = 1'b0;
        en_off    = 1'b0;
        if (frame_tick) begin
            case (state)
                IDLE: begin
                    if (any) begin
                        grant     = 1'b1;
                        state_nxt = SHOW;
                    end
                end
                SHOW: begin
                    if (dwell != '0) begin
                        dwell_dec = 1'b1;
                    end else if (any) begin
                        grant = 1'b1;
                    end else begin
                        en_off    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // vb_prev resets high so a VBLANK already asserted at release is not an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vb_prev    <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            if (pixel_ce) vb_prev <= VBLANK;
            frame_tick <= pixel_ce & VBLANK & ~vb_prev;
        end
    end

    // Shadow holds the pre-capture value during a same-cycle grant; set beats clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow  <= '0;
            pending <= '0;
            req_ack <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i]) shadow[i] <= req_value[i*DBG_W +: DBG_W];
            end
            pending <= (pending & ~clr) | req_valid;
            req_ack <= req_valid;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            debug_value <= '0;
            debug_src   <= '0;
            osd_enable  <= 1'b0;
            last_src    <= LAST_RST;
            dwell       <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                debug_value <= sel_val;
                debug_src   <= sel;
                last_src    <= sel;
                dwell       <= DWELL_INIT;
                osd_enable  <= 1'b1;
            end else if (dwell_dec) begin
                dwell <= dwell - DW'(1);
            end else if (en_off) begin
                osd_enable <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_osd_debug_scheduler.sv
// Directed bench: dut_a uses DWELL_FRAMES=60, dut_b uses DWELL_FRAMES=1.
module tb_osd_debug_scheduler;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pce = 1'b1;
    logic [1:0]  vb = 2'b11;
    logic [3:0]  rv_a = '0, rv_b = '0;
    logic [31:0] val_a = '0, val_b = '0;

    logic [3:0] ack_a, ack_b;
    logic [7:0] dv_a, dv_b;
    logic [2:0] src_a, src_b;
    logic       en_a, en_b, tick_a, tick_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    osd_debug_scheduler #(.NUM_REQ(4), .DWELL_FRAMES(60), .DBG_W(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .pixel_ce(pce), .VBLANK(vb[0]),
        .req_valid(rv_a), .req_value(val_a), .req_ack(ack_a),
        .debug_value(dv_a), .debug_src(src_a), .osd_enable(en_a), .frame_tick(tick_a)
    );

    osd_debug_scheduler #(.NUM_REQ(4), .DWELL_FRAMES(1), .DBG_W(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .pixel_ce(pce), .VBLANK(vb[1]),
        .req_valid(rv_b), .req_value(val_b), .req_ack(ack_b),
        .debug_value(dv_b), .debug_src(src_b), .osd_enable(en_b), .frame_tick(tick_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Low-high VBLANK pulse; returns one cycle after the registered tick.
    task automatic do_tick(input int d, input logic [3:0] post);
        vb[d] = 1'b0;
        step();
        step();
        vb[d] = 1'b1;
        step();
        if (post != 4'b0) rv_b = post;
        step();
        rv_b = 4'b0;
    endtask

    initial begin
        repeat (2) step();
        reset_n = 1'b1;
        step();
        check("rst_en_a", en_a, 0);
        check("rst_dv_a", dv_a, 0);
        check("rst_src_a", src_a, 0);
        check("rst_ack_a", ack_a, 0);
        check("rst_en_b", en_b, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("no_tick_vb_high", tick_a, 0);
        end

        vb[0] = 1'b0;
        step();
        step();
        vb[0] = 1'b1;
        step();
        check("tick_pulse", tick_a, 1);
        step();
        check("tick_one_cycle", tick_a, 0);
        check("idle_no_pending", en_a, 0);

        val_a[23:16] = 8'hA5;
        rv_a = 4'b0100;
        step();
        rv_a = 4'b0;
        check("ack2", ack_a, 4'b0100);
        step();
        check("ack2_clear", ack_a, 0);
        check("no_show_before_tick", en_a, 0);
        do_tick(0, 4'b0);
        check("grant2_dv", dv_a, 8'hA5);
        check("grant2_src", src_a, 2);
        check("grant2_en", en_a, 1);
        for (int i = 1; i <= 59; i++) do_tick(0, 4'b0);
        check("dwell60_en", en_a, 1);
        check("dwell60_dv", dv_a, 8'hA5);
        do_tick(0, 4'b0);
        check("tick61_off", en_a, 0);
        check("tick61_dv_hold", dv_a, 8'hA5);
        check("tick61_src_hold", src_a, 2);

        vb[1] = 1'b0;
        step();
        step();
        pce = 1'b0;
        vb[1] = 1'b1;
        step();
        step();
        check("ce_gated_tick", tick_b, 0);
        pce = 1'b1;
        step();
        check("ce_tick", tick_b, 1);
        step();
        check("ce_tick_end", tick_b, 0);

        val_b = 32'h33_00_22_11;
        rv_b = 4'b1011;
        step();
        rv_b = 4'b0;
        check("ack_multi", ack_b, 4'b1011);
        do_tick(1, 4'b0);
        check("rr0_dv", dv_b, 8'h11);
        check("rr0_src", src_b, 0);
        check("rr0_en", en_b, 1);
        do_tick(1, 4'b0);
        check("rr1_dv", dv_b, 8'h22);
        check("rr1_src", src_b, 1);
        do_tick(1, 4'b0);
        check("rr3_dv", dv_b, 8'h33);
        check("rr3_src", src_b, 3);
        do_tick(1, 4'b0);
        check("rr_done_en", en_b, 0);
        check("rr_done_dv", dv_b, 8'h33);
        check("rr_done_src", src_b, 3);

        val_b[15:8] = 8'h55;
        rv_b = 4'b0010;
        step();
        rv_b = 4'b0;
        do_tick(1, 4'b0);
        check("s1_dv", dv_b, 8'h55);
        check("s1_src", src_b, 1);
        val_b[15:8] = 8'h66;
        rv_b = 4'b0010;
        step();
        rv_b = 4'b0;
        val_b[15:8] = 8'h7E;
        do_tick(1, 4'b0010);
        check("same_cyc_old_val", dv_b, 8'h66);
        check("same_cyc_src", src_b, 1);
        check("same_cyc_ack", ack_b, 4'b0010);
        do_tick(1, 4'b0);
        check("same_cyc_new_val", dv_b, 8'h7E);
        check("same_cyc_new_en", en_b, 1);
        do_tick(1, 4'b0);
        check("same_cyc_idle", en_b, 0);

        val_b[7:0] = 8'h10;
        rv_b = 4'b0001;
        step();
        check("repost_ack1", ack_b, 4'b0001);
        val_b[7:0] = 8'h20;
        step();
        check("repost_ack2", ack_b, 4'b0001);
        rv_b = 4'b0;
        step();
        check("repost_ack_end", ack_b, 0);
        do_tick(1, 4'b0);
        check("latest_wins_dv", dv_b, 8'h20);
        check("latest_wins_src", src_b, 0);
        check("latest_wins_en", en_b, 1);

        val_a[31:24] = 8'h3C;
        rv_a = 4'b1000;
        step();
        rv_a = 4'b0;
        do_tick(0, 4'b0);
        check("pre_rst_dv", dv_a, 8'h3C);
        check("pre_rst_src", src_a, 3);
        check("pre_rst_en", en_a, 1);
        val_a[15:8] = 8'h99;
        rv_a = 4'b0010;
        step();
        rv_a = 4'b0;
        vb[0] = 1'b0;
        step();
        step();
        vb[0] = 1'b1;
        step();
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_en", en_a, 0);
        check("async_rst_dv", dv_a, 0);
        check("async_rst_src", src_a, 0);
        check("async_rst_tick", tick_a, 0);
        check("async_rst_en_b", en_b, 0);
        check("async_rst_dv_b", dv_b, 0);
        step();
        step();
        reset_n = 1'b1;
        step();
        step();
        check("post_rst_no_tick", tick_a, 0);
        do_tick(0, 4'b0);
        check("post_rst_pending_clr", en_a, 0);
        val_a[7:0]   = 8'h01;
        val_a[23:16] = 8'h02;
        rv_a = 4'b0101;
        step();
        rv_a = 4'b0;
        do_tick(0, 4'b0);
        check("post_rst_src0_first", src_a, 0);
        check("post_rst_dv", dv_a, 8'h01);
        check("post_rst_en", en_a, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
